// File: rtl/tc_pkg.sv
// ---------------------------------------------------------------------------
// tc_pkg
//   Shared constants for the multi-channel timer/counter (tc_multi).
//   - Per-channel register offsets (PrAddr[1:0])
//   - MODE field encodings
//   - CTRL register bit positions
//   Optional feature macro used by the design files: TC_PWM_EN.
// ---------------------------------------------------------------------------
package tc_pkg;

    // Register offsets inside one channel's 4-word window
    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;
    localparam logic [1:0] TC_CMP    = 2'd3;

    // MODE encodings; 11 is an alias of one-shot
    localparam logic [1:0] TC_MODE_ONESHOT     = 2'd0;
    localparam logic [1:0] TC_MODE_RELOAD      = 2'd1;
    localparam logic [1:0] TC_MODE_PWM         = 2'd2;
    localparam logic [1:0] TC_MODE_ONESHOT_ALT = 2'd3;

    // CTRL bit positions
    localparam int TC_CTRL_EN      = 0;
    localparam int TC_CTRL_MODE_LO = 1;
    localparam int TC_CTRL_MODE_HI = 2;
    localparam int TC_CTRL_IM      = 3;
    localparam int TC_CTRL_IP      = 4;

endpackage

// File: rtl/tc_channel.sv
// ---------------------------------------------------------------------------
// tc_channel
//   One timer channel: CTRL/PRESET/COUNT(/CMP) registers, down-counter,
//   expire detection, sticky interrupt-pending bit and PWM compare.
//   Optional feature macro: TC_PWM_EN (adds CMP register and o_pwm).
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   i_we     in   write strobe already qualified for this channel
//   i_reg    in   register offset (read and write select)
//   i_wdata  in   write data
//   o_rdata  out  read data for i_reg, zero-extended to 32 bits
//   o_irq    out  IP & IM
//   o_pwm    out  PWM level (TC_PWM_EN only)
// ---------------------------------------------------------------------------
module tc_channel
    import tc_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [1:0]  i_reg,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
`ifdef TC_PWM_EN
    ,
    output logic        o_pwm
`endif
);

    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic             r_ip;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;

    logic             w_we_ctrl;
    logic             w_we_preset;
    logic             w_tick;
    logic             w_expire;
    logic             w_oneshot;
    logic [CNT_W-1:0] w_wval;

    assign w_wval      = i_wdata[CNT_W-1:0];
    assign w_we_ctrl   = i_we && (i_reg == TC_CTRL);
    assign w_we_preset = i_we && (i_reg == TC_PRESET);

    // A zero count never ticks, so PRESET=0 can never expire
    assign w_tick    = r_en && (r_count != '0);
    assign w_expire  = w_tick && (r_count == CNT_W'(1));
    // Without TC_PWM_EN, MODE 10 falls into the reload path as well
    assign w_oneshot = (r_mode == TC_MODE_ONESHOT) || (r_mode == TC_MODE_ONESHOT_ALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_mode   <= TC_MODE_ONESHOT;
            r_im     <= 1'b0;
            r_ip     <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
        end else begin
            // COUNT: a PRESET write beats both reload and decrement.
            // One-shot expiry needs no special case: COUNT-1 is already 0.
            if (w_we_preset) begin
                r_count <= w_wval;
            end else if (w_expire && !w_oneshot) begin
                r_count <= r_preset;
            end else if (w_tick) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (w_we_preset) begin
                r_preset <= w_wval;
            end

            // A CTRL write on the expire edge overrides one-shot auto-disable
            if (w_we_ctrl) begin
                r_en   <= i_wdata[TC_CTRL_EN];
                r_mode <= i_wdata[TC_CTRL_MODE_HI:TC_CTRL_MODE_LO];
                r_im   <= i_wdata[TC_CTRL_IM];
            end else if (w_expire && w_oneshot) begin
                r_en <= 1'b0;
            end

            // Set beats W1C so an interrupt is never lost
            if (w_expire) begin
                r_ip <= 1'b1;
            end else if (w_we_ctrl && i_wdata[TC_CTRL_IP]) begin
                r_ip <= 1'b0;
            end
        end
    end

`ifdef TC_PWM_EN
    logic [CNT_W-1:0] r_cmp;
    logic             w_we_cmp;

    assign w_we_cmp = i_we && (i_reg == TC_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp <= '0;
        end else if (w_we_cmp) begin
            r_cmp <= w_wval;
        end
    end

    assign o_pwm = r_en && (r_mode == TC_MODE_PWM) &&
                   (r_count <= r_cmp) && (r_count != '0);
`endif

    assign o_irq = r_ip & r_im;

    always_comb begin
        o_rdata = '0;
        case (i_reg)
            TC_CTRL:   o_rdata[4:0] = {r_ip, r_im, r_mode, r_en};
            TC_PRESET: o_rdata      = 32'(r_preset);
            TC_COUNT:  o_rdata      = 32'(r_count);
`ifdef TC_PWM_EN
            TC_CMP:    o_rdata      = 32'(r_cmp);
`else
            TC_CMP:    o_rdata      = '0;
`endif
            default:   o_rdata      = '0;
        endcase
    end

endmodule

// File: rtl/tc_multi.sv
// ---------------------------------------------------------------------------
// tc_multi
//   N_CH independent down-counting timer channels on the CPU peripheral bus.
//   Word address: PrAddr[ADDR_W-1:2] selects the channel, PrAddr[1:0] the
//   register (CTRL, PRESET, COUNT, CMP). Channel numbers >= N_CH ignore
//   writes and read 0.
//   Optional feature macro: TC_PWM_EN (CMP registers and pwm_out port).
// Ports
//   clk               in   system clock
//   reset             in   synchronous active-high reset
//   PrAddr            in   word address
//   WE                in   write strobe
//   DataIn            in   write data
//   DataOut           out  read data, combinational from PrAddr
//   InterruptRequest  out  OR over channels of (IP & IM)
//   pwm_out           out  per-channel PWM (TC_PWM_EN only)
// ---------------------------------------------------------------------------
module tc_multi
    import tc_pkg::*;
#(
    parameter  int N_CH   = 2,
    parameter  int CNT_W  = 32,
    localparam int ADDR_W = $clog2(N_CH) + 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PrAddr,
    input  logic              WE,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              InterruptRequest
`ifdef TC_PWM_EN
    ,
    output logic [N_CH-1:0]   pwm_out
`endif
);

    // Shift rather than slice so N_CH=1 (empty channel field) still works
    logic [ADDR_W-1:0] w_ch_sel;
    logic [31:0]       w_rdata [N_CH];
    logic [N_CH-1:0]   w_irq;

    assign w_ch_sel = PrAddr >> 2;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tc_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_we    (WE && (w_ch_sel == ADDR_W'(g))),
            .i_reg   (PrAddr[1:0]),
            .i_wdata (DataIn),
            .o_rdata (w_rdata[g]),
            .o_irq   (w_irq[g])
`ifdef TC_PWM_EN
            ,
            .o_pwm   (pwm_out[g])
`endif
        );
    end

    always_comb begin
        DataOut = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch_sel == ADDR_W'(i)) begin
                DataOut = w_rdata[i];
            end
        end
    end

    assign InterruptRequest = |w_irq;

endmodule

// File: tb/tb_tc_multi.sv
// ---------------------------------------------------------------------------
// tb_tc_multi
//   Self-checking bench for tc_multi (default N_CH=2, CNT_W=32).
//   Directed vector table, hand-written corner sequences, then random bus
//   traffic against a cycle-level reference model. Honours TC_PWM_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tc_multi;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 32;
    localparam int ADDR_W = 3;
    localparam logic [31:0] MASK = (CNT_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] PrAddr;
    logic              WE;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              InterruptRequest;
`ifdef TC_PWM_EN
    logic [N_CH-1:0]   pwm_out;
`endif

    always #50 clk = ~clk;

    tc_multi #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .PrAddr           (PrAddr),
        .WE               (WE),
        .DataIn           (DataIn),
        .DataOut          (DataOut),
        .InterruptRequest (InterruptRequest)
`ifdef TC_PWM_EN
        ,
        .pwm_out          (pwm_out)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers (called at a negedge) ----------------
    // Present one bus cycle, let one rising edge pass, return at the next negedge
    task automatic step(input bit we, input int addr, input logic [31:0] data);
        WE     = we;
        PrAddr = ADDR_W'(addr);
        DataIn = data;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic check_rd(input string name, input int addr, input logic [31:0] exp);
        PrAddr = ADDR_W'(addr);
        #1;
        check(name, DataOut, exp);
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        WE    = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit          m_en   [N_CH];
    logic [1:0]  m_mode [N_CH];
    bit          m_im   [N_CH];
    bit          m_ip   [N_CH];
    logic [31:0] m_preset [N_CH];
    logic [31:0] m_count  [N_CH];
    logic [31:0] m_cmp    [N_CH];

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_ip[c] = 0;
            m_preset[c] = 0; m_count[c] = 0; m_cmp[c] = 0;
        end
    endtask

    // One rising edge: timer rules first, then bus-write overrides
    task automatic model_edge(input bit we, input int addr, input logic [31:0] data);
        for (int c = 0; c < N_CH; c++) begin
            bit wr;
            bit ev;
            int r;
            wr = we && ((addr >> 2) == c);
            r  = addr & 3;
            ev = m_en[c] && (m_count[c] == 1);
            if (m_en[c] && m_count[c] != 0) begin
                m_count[c] = m_count[c] - 1;
                if (ev) begin
                    m_ip[c] = 1;
                    if (m_mode[c] == 0 || m_mode[c] == 3) m_en[c] = 0;
                    else m_count[c] = m_preset[c];
                end
            end
            if (wr) begin
                case (r)
                    0: begin
                        m_en[c]   = data[0];
                        m_mode[c] = data[2:1];
                        m_im[c]   = data[3];
                        if (data[4] && !ev) m_ip[c] = 0;
                    end
                    1: begin
                        m_preset[c] = data & MASK;
                        m_count[c]  = data & MASK;
                    end
`ifdef TC_PWM_EN
                    3: m_cmp[c] = data & MASK;
`endif
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int addr);
        int c;
        c = addr >> 2;
        if (c >= N_CH) return 32'd0;
        case (addr & 3)
            0: return {27'd0, m_ip[c], m_im[c], m_mode[c], m_en[c]};
            1: return m_preset[c];
            2: return m_count[c];
            default: return m_cmp[c];
        endcase
    endfunction

    function automatic logic model_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < N_CH; c++) v = v | (m_ip[c] & m_im[c]);
        return v;
    endfunction

`ifdef TC_PWM_EN
    function automatic logic [N_CH-1:0] model_pwm();
        logic [N_CH-1:0] p;
        for (int c = 0; c < N_CH; c++)
            p[c] = m_en[c] && m_mode[c] == 2 && m_count[c] <= m_cmp[c] && m_count[c] != 0;
        return p;
    endfunction
`endif

    // ---------------- vector table ----------------
    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] data;
        int          raddr;
        logic [31:0] exp_rd;
        bit          exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit we, input int addr, input logic [31:0] data,
                                input int raddr, input logic [31:0] exp_rd,
                                input bit exp_irq, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data;
        v.raddr = raddr; v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.name = name;
        vecs.push_back(v);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] seq3 [9];
        logic [31:0] seq6 [8];
        logic [31:0] cmp_exp5;
        logic [31:0] cmp_exp2;
        int          pwm_high;

        reset  = 1'b1;
        WE     = 1'b0;
        PrAddr = '0;
        DataIn = '0;
        @(negedge clk);

`ifdef TC_PWM_EN
        cmp_exp5 = 32'd5;
        cmp_exp2 = 32'd2;
`else
        cmp_exp5 = 32'd0;
        cmp_exp2 = 32'd0;
`endif

        // Reset held two cycles: everything reads zero
        apply_reset(2);
        for (int a = 0; a < 8; a++) check_rd($sformatf("reset_reg%0d", a), a, 32'd0);
        check("reset_irq", 32'(InterruptRequest), 32'd0);
`ifdef TC_PWM_EN
        check("reset_pwm", 32'(pwm_out), 32'd0);
`endif

        // Channel 0 one-shot PRESET=10, then IM=0 one-shot PRESET=2, W1C, COUNT/CMP writes
        add(1, 1, 10,   2, 10,   0, "os_preset");
        add(1, 0, 'h9,  2, 10,   0, "os_start");
        for (int k = 9; k >= 1; k--) add(0, 0, 0, 2, k, 0, "os_count");
        add(0, 0, 0,    2, 0,    1, "os_expire");
        add(0, 0, 0,    0, 'h18, 1, "os_ctrl");
        add(1, 0, 'h10, 0, 'h00, 0, "os_w1c");
        add(1, 1, 2,    2, 2,    0, "nim_preset");
        add(1, 0, 'h1,  2, 2,    0, "nim_start");
        add(0, 0, 0,    2, 1,    0, "nim_count");
        add(0, 0, 0,    0, 'h10, 0, "nim_ip_masked");
        add(1, 0, 'h8,  0, 'h18, 1, "nim_unmask");
        add(1, 0, 'h10, 0, 'h00, 0, "nim_w1c");
        add(1, 2, 'h55, 2, 0,    0, "count_wr_ignored");
        add(1, 3, 5,    3, cmp_exp5, 0, "cmp_wr");

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].data);
            check_rd(vecs[i].name, vecs[i].raddr, vecs[i].exp_rd);
            check({vecs[i].name, "_irq"}, 32'(InterruptRequest), 32'(vecs[i].exp_irq));
        end

        // Channel 1 auto-reload, PRESET=3
        seq3 = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        step(1, 5, 3);
        step(1, 4, 'hB);
        check_rd("ar_start", 6, 3);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0);
            check_rd("ar_count", 6, seq3[i]);
            check_rd("ar_ctrl", 4, (i >= 2) ? 32'h1B : 32'h0B);
            check("ar_irq", 32'(InterruptRequest), (i >= 2) ? 32'd1 : 32'd0);
        end
        step(1, 4, 'h1B);
        check_rd("ar_w1c", 4, 'h0B);
        check("ar_w1c_irq", 32'(InterruptRequest), 0);
        step(0, 0, 0);
        check_rd("ar_w1c_p1", 4, 'h0B);
        step(0, 0, 0);
        check_rd("ar_reset_ip", 4, 'h1B);
        check_rd("ar_reset_cnt", 6, 3);
        check("ar_reset_irq", 32'(InterruptRequest), 1);

        // PRESET=4; W1C on the expire edge, then PRESET write on the expire edge
        step(1, 5, 4);
        check_rd("e_preset", 6, 4);
        step(1, 4, 'h1B);
        check_rd("e_clear", 4, 'h0B);
        step(0, 0, 0);
        step(0, 0, 0);
        check_rd("e_count1", 6, 1);
        step(1, 4, 'h1B);
        check_rd("e_w1c_vs_set", 4, 'h1B);
        check_rd("e_reload", 6, 4);
        check("e_w1c_irq", 32'(InterruptRequest), 1);
        step(1, 4, 'h1B);
        step(0, 0, 0);
        step(0, 0, 0);
        check_rd("e_count1b", 6, 1);
        step(1, 5, 7);
        check_rd("e_preset_wins", 6, 7);
        check_rd("e_preset_ip", 4, 'h1B);
        step(1, 4, 'h10);
        check("ch1_stop_irq", 32'(InterruptRequest), 0);

        // Channel 0: CTRL write on one-shot expire keeps EN; zero count holds; freeze/resume
        step(1, 1, 2);
        step(1, 0, 'h1);
        step(0, 0, 0);
        step(1, 0, 'h9);
        check_rd("os_ctrl_wins", 0, 'h19);
        check_rd("os_ctrl_cnt", 2, 0);
        step(0, 0, 0);
        check_rd("zero_no_tick", 2, 0);
        check_rd("zero_ctrl", 0, 'h19);
        step(1, 1, 5);
        step(0, 0, 0);
        check_rd("fr_run", 2, 4);
        step(1, 0, 'h10);
        check_rd("fr_stop_edge", 2, 3);
        step(0, 0, 0);
        check_rd("fr_hold", 2, 3);
        step(1, 0, 'h1);
        check_rd("fr_resume_edge", 2, 3);
        step(0, 0, 0);
        check_rd("fr_resume", 2, 2);

        // MODE 10, PRESET=4, CMP=2 (PWM with the macro, plain reload without)
        seq6 = '{3, 2, 1, 4, 3, 2, 1, 4};
        step(1, 0, 'h0);
        step(1, 1, 4);
        step(1, 3, 2);
        check_rd("pwm_cmp", 3, cmp_exp2);
        step(1, 0, 'h5);
        check_rd("pwm_start", 2, 4);
        pwm_high = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            check_rd("pwm_count", 2, seq6[i]);
`ifdef TC_PWM_EN
            check("pwm_level", 32'(pwm_out[0]), (seq6[i] <= 2) ? 32'd1 : 32'd0);
            check("pwm_ch1_low", 32'(pwm_out[1]), 0);
            if (pwm_out[0]) pwm_high++;
`endif
        end
`ifdef TC_PWM_EN
        check("pwm_duty", 32'(pwm_high), 4);
`endif

        // Reset while channel 0 is counting
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) check_rd($sformatf("midreset_reg%0d", a), a, 32'd0);
        check("midreset_irq", 32'(InterruptRequest), 0);

        // Random bus traffic against the model
        model_reset();
        for (int it = 0; it < 500; it++) begin
            int          ra;
            int          wa;
            bit          we;
            logic [31:0] d;
            check("rand_irq", 32'(InterruptRequest), 32'(model_irq()));
`ifdef TC_PWM_EN
            check("rand_pwm", 32'(pwm_out), 32'(model_pwm()));
`endif
            ra = $urandom_range(0, 7);
            check_rd($sformatf("rand_rd%0d", ra), ra, model_read(ra));
            we = ($urandom_range(0, 2) == 0);
            wa = $urandom_range(0, 7);
            if ((wa & 3) == 1 || (wa & 3) == 3) d = $urandom_range(0, 6);
            else d = $urandom_range(0, 31);
            model_edge(we, wa, d);
            step(we, wa, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
